store_commit_queue: RTL

// - In-order store buffer that acts as the initiator of the data-memory store port.
// - Stores are allocated at dispatch in program order; address and data are filled in from FU Mem; the ROB marks them committed.
// - Committed head entries are drained to data memory, one per cycle, as a store_wb pulse plus an lsq_out payload.
// - Also produces load_mem, the disambiguation grant: a load may read memory only when no older store could alias it.

---
 rtl/store_commit_queue_if.sv | 51 +++++
 rtl/store_commit_queue.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/store_commit_queue_if.sv
// Store commit queue bus: dispatch allocation, FU Mem fill, ROB commit/flush,
// load disambiguation query and the drained-store output towards data memory.
interface store_commit_queue_if #(
    parameter int ROB_BITS = 5
);
    typedef struct packed {
        logic [31:0]         addr;
        logic [31:0]         ps2_data;
        logic                sw_sh_signal;
        logic [ROB_BITS-1:0] rob_tag;
    } lsq_t;

    // Allocation is a valid/ready transfer: one store enters when alloc_valid
    // is high at a rising edge while alloc_ready is high (or the queue is full
    // but its head drains in that same cycle). fill, commit and flush are
    // one-cycle commands with no back-pressure. store_wb is a one-cycle strobe
    // with no ready: lsq_out is meaningful only while store_wb is high.
    logic                alloc_valid;
    logic [ROB_BITS-1:0] alloc_rob;
    logic                alloc_is_sh;
    logic                alloc_ready;
    logic                fill_valid;
    logic [ROB_BITS-1:0] fill_rob;
    logic [31:0]         fill_addr;
    logic [31:0]         fill_data;
    logic                commit_valid;
    logic [ROB_BITS-1:0] commit_rob;
    logic                flush;
    logic [ROB_BITS-1:0] rob_head;
    logic                ld_check;
    logic [ROB_BITS-1:0] ld_rob;
    logic [31:0]         ld_addr;
    logic                load_mem;
    logic                store_wb;
    lsq_t                lsq_out;
    logic                empty;

    modport master (
        output alloc_valid, alloc_rob, alloc_is_sh, fill_valid, fill_rob, fill_addr,
               fill_data, commit_valid, commit_rob, flush, rob_head, ld_check, ld_rob,
               ld_addr,
        input  alloc_ready, load_mem, store_wb, lsq_out, empty
    );

    modport slave (
        input  alloc_valid, alloc_rob, alloc_is_sh, fill_valid, fill_rob, fill_addr,
               fill_data, commit_valid, commit_rob, flush, rob_head, ld_check, ld_rob,
               ld_addr,
        output alloc_ready, load_mem, store_wb, lsq_out, empty
    );
endinterface

// File: rtl/store_commit_queue.sv
// In-order store buffer: allocate at dispatch, fill from FU Mem, commit from
// the ROB, drain committed head stores to memory, and grant non-aliasing loads.
module store_commit_queue #(
    parameter int DEPTH    = 8,
    parameter int ROB_BITS = 5,
    localparam int PTR_W   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    store_commit_queue_if.slave bus,
    output logic [PTR_W:0]   dbg_count_o,
    output logic [PTR_W-1:0] dbg_head_o,
    output logic [PTR_W-1:0] dbg_tail_o
);
    logic [DEPTH-1:0]    valid_q, valid_d;
    logic [DEPTH-1:0]    addr_ok_q, addr_ok_d;
    logic [DEPTH-1:0]    committed_q, committed_d;
    logic [DEPTH-1:0]    is_sh_q, is_sh_d;
    logic [ROB_BITS-1:0] rob_q  [DEPTH];
    logic [ROB_BITS-1:0] rob_d  [DEPTH];
    logic [31:0]         addr_q [DEPTH];
    logic [31:0]         addr_d [DEPTH];
    logic [31:0]         data_q [DEPTH];
    logic [31:0]         data_d [DEPTH];

    logic [PTR_W-1:0]    head_q, head_d, tail_q, tail_d;
    logic [PTR_W:0]      count_q, count_d;
    logic [PTR_W:0]      keep;
    logic [PTR_W-1:0]    idx;
    logic                found;
    logic                drain, alloc_fire;

    logic                store_wb_q;
    logic [31:0]         lsq_addr_q, lsq_data_q;
    logic                lsq_sh_q;
    logic [ROB_BITS-1:0] lsq_rob_q;

    logic [DEPTH-1:0]    blocks;
    logic                unused_ld_lsb;

    assign drain      = valid_q[head_q] && committed_q[head_q] && addr_ok_q[head_q];
    // A full queue may still accept when its head drains this cycle.
    assign alloc_fire = bus.alloc_valid && !bus.flush && ((count_q != DEPTH[PTR_W:0]) || drain);

    always_comb begin
        valid_d     = valid_q;
        addr_ok_d   = addr_ok_q;
        committed_d = committed_q;
        is_sh_d     = is_sh_q;
        rob_d       = rob_q;
        addr_d      = addr_q;
        data_d      = data_q;
        keep        = count_q;
        found       = 1'b0;
        idx         = '0;

        for (int i = 0; i < DEPTH; i++) begin
            if (bus.fill_valid && valid_q[i] && rob_q[i] == bus.fill_rob) begin
                addr_d[i]    = bus.fill_addr;
                data_d[i]    = bus.fill_data;
                addr_ok_d[i] = 1'b1;
            end
            if (bus.commit_valid && valid_q[i] && rob_q[i] == bus.commit_rob)
                committed_d[i] = 1'b1;
        end

        // Commits are contiguous from head, so the first uncommitted slot is the new tail.
        if (bus.flush) begin
            for (int k = 0; k < DEPTH; k++) begin
                idx = head_q + PTR_W'(k);
                if (!found && (PTR_W + 1)'(k) < count_q && !committed_d[idx]) begin
                    keep  = (PTR_W + 1)'(k);
                    found = 1'b1;
                end
            end
            for (int i = 0; i < DEPTH; i++)
                if (!committed_d[i]) valid_d[i] = 1'b0;
        end

        if (drain) begin
            valid_d[head_q]     = 1'b0;
            committed_d[head_q] = 1'b0;
            addr_ok_d[head_q]   = 1'b0;
        end

        if (alloc_fire) begin
            valid_d[tail_q]     = 1'b1;
            addr_ok_d[tail_q]   = 1'b0;
            committed_d[tail_q] = 1'b0;
            is_sh_d[tail_q]     = bus.alloc_is_sh;
            rob_d[tail_q]       = bus.alloc_rob;
        end
    end

    always_comb begin
        head_d = head_q + PTR_W'(drain);
        if (bus.flush) begin
            tail_d  = head_q + keep[PTR_W-1:0];
            count_d = keep - (PTR_W + 1)'(drain);
        end else begin
            tail_d  = tail_q + PTR_W'(alloc_fire);
            count_d = count_q + (PTR_W + 1)'(alloc_fire) - (PTR_W + 1)'(drain);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q     <= '0;
            addr_ok_q   <= '0;
            committed_q <= '0;
            is_sh_q     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rob_q[i]  <= '0;
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            store_wb_q  <= 1'b0;
            lsq_addr_q  <= '0;
            lsq_data_q  <= '0;
            lsq_sh_q    <= 1'b0;
            lsq_rob_q   <= '0;
        end else begin
            valid_q     <= valid_d;
            addr_ok_q   <= addr_ok_d;
            committed_q <= committed_d;
            is_sh_q     <= is_sh_d;
            rob_q       <= rob_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            store_wb_q  <= drain;
            if (drain) begin
                lsq_addr_q <= addr_q[head_q];
                lsq_data_q <= data_q[head_q];
                lsq_sh_q   <= is_sh_q[head_q];
                lsq_rob_q  <= rob_q[head_q];
            end
        end
    end

    // Ages are distances from the ROB head, so tag wrap-around orders correctly.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            blocks[i] = valid_q[i]
                && (ROB_BITS'(rob_q[i] - bus.rob_head) < ROB_BITS'(bus.ld_rob - bus.rob_head))
                && (!addr_ok_q[i] || addr_q[i][31:2] == bus.ld_addr[31:2]);
        end
    end

    assign unused_ld_lsb   = ^bus.ld_addr[1:0];
    assign bus.load_mem    = bus.ld_check && (blocks == '0);
    assign bus.alloc_ready = (count_q != DEPTH[PTR_W:0]);
    assign bus.empty       = (count_q == '0);
    assign bus.store_wb    = store_wb_q;
    assign bus.lsq_out     = {lsq_addr_q, lsq_data_q, lsq_sh_q, lsq_rob_q};
    assign dbg_count_o     = count_q;
    assign dbg_head_o      = head_q;
    assign dbg_tail_o      = tail_q;
endmodule
